// File: rtl/dram_port_arbiter_if.sv
// Requester and DRAM-side signal bundle for dram_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface dram_port_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            i_req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_rsp_valid;
  logic [DATA_WIDTH-1:0]         o_rsp_rdata;
  logic                          o_dram_we;
  logic                          o_dram_re;
  logic [ADDR_WIDTH-1:0]         o_dram_addr;
  logic [DATA_WIDTH-1:0]         o_dram_wdata;
  logic [DATA_WIDTH-1:0]         i_dram_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_dram_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata,
    output o_dram_we, o_dram_re, o_dram_addr, o_dram_wdata
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_dram_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata,
    input  o_dram_we, o_dram_re, o_dram_addr, o_dram_wdata
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one DRAM port among NUM_REQ requesters.
// Define DRAM_ARB_HOST_PRIORITY_EN to give requester 0 strict priority.
module dram_port_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  dram_port_arbiter_if.slave bus,
  output logic               o_busy
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW = GW + 1;
  localparam int CW = $clog2(READ_LATENCY + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [GW-1:0]         owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  any_valid;
  logic                  found;
  logic [GW-1:0]         winner;
  logic [IW-1:0]         idx;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    rsp_valid;

  assign any_valid = |bus.i_req_valid;

  // Search upward from the requester after last_grant, wrapping mod NUM_REQ.
  always_comb begin
    winner = last_grant_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, last_grant_q} + IW'(i);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      if (!found && bus.i_req_valid[idx[GW-1:0]]) begin
        found  = 1'b1;
        winner = idx[GW-1:0];
      end
    end
`ifdef DRAM_ARB_HOST_PRIORITY_EN
    if (bus.i_req_valid[0]) winner = '0;
`endif
  end

  always_comb begin
    ready = '0;
    if (state_q == S_IDLE && any_valid) ready[winner] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          owner_d = winner;
          we_d    = bus.i_req_we[winner];
          addr_d  = bus.i_req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = bus.i_req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
`ifdef DRAM_ARB_HOST_PRIORITY_EN
          // Host grants leave the rotation among the other requesters untouched.
          if (winner != '0) last_grant_d = winner;
`else
          last_grant_d = winner;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CW'(READ_LATENCY);
          state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (cnt_q == CW'(1)) begin
          rdata_d = bus.i_dram_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      owner_q      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[owner_q] = 1'b1;
  end

  // Strobes decode from state so they fall with the asynchronous reset.
  assign bus.o_req_ready  = ready;
  assign bus.o_rsp_valid  = rsp_valid;
  assign bus.o_rsp_rdata  = rdata_q;
  assign bus.o_dram_we    = (state_q == S_ISSUE) &  we_q;
  assign bus.o_dram_re    = (state_q == S_ISSUE) & ~we_q;
  assign bus.o_dram_addr  = addr_q;
  assign bus.o_dram_wdata = wdata_q;
  assign o_busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: vector table plus multi-cycle
// sequences, with DRAM strobes and read responses checked against a scoreboard.
module tb_dram_port_arbiter;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  dram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dif ();

  dram_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif),
    .o_busy(busy)
  );

  typedef struct {
    int          req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } iss_t;

  typedef struct {
    int          owner;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  iss_t mi;
  rsp_t mr;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'h1234_5678 : (a ^ 32'hC0DE_0000);
  endfunction

  // DRAM model: data for a read strobe appears RL cycles after the strobe.
  logic        pvld [RL];
  logic [31:0] pdat [RL];
  always @(posedge clk) begin
    pvld[0] <= dif.o_dram_re;
    pdat[0] <= rd_model(dif.o_dram_addr);
    for (int i = 1; i < RL; i++) begin
      pvld[i] <= pvld[i-1];
      pdat[i] <= pdat[i-1];
    end
  end
  assign dif.i_dram_rdata = pvld[RL-1] ? pdat[RL-1] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (|dif.o_req_ready) begin
      chk("ready onehot", 64'($countones(dif.o_req_ready)), 1);
      chk("ready only when idle", busy, 0);
    end
    if (dif.o_dram_we || dif.o_dram_re) begin
      if (iss_q.size() == 0) begin
        chk("unexpected dram strobe", {dif.o_dram_we, dif.o_dram_re}, 0);
      end else begin
        mi = iss_q.pop_front();
        chk("dram we/re", {dif.o_dram_we, dif.o_dram_re}, {mi.we, ~mi.we});
        chk("dram addr", dif.o_dram_addr, mi.addr);
        chk("dram wdata", dif.o_dram_wdata, mi.wdata);
        chk("dram strobe cycle", cyc, mi.cyc);
      end
    end
    if (|dif.o_rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected rsp_valid", dif.o_rsp_valid, 0);
      end else begin
        mr = rsp_q.pop_front();
        chk("rsp_valid owner", dif.o_rsp_valid, 64'(1) << mr.owner);
        chk("rsp_rdata", dif.o_rsp_rdata, mr.rdata);
        chk("rsp cycle", cyc, mr.cyc);
      end
    end
  end

  task automatic push_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input int at, input int owner, input logic [31:0] exp_rd);
    iss_q.push_back('{we, a, wd, at + 1});
    if (!we) rsp_q.push_back('{owner, exp_rd, at + RL + 2});
  endtask

  task automatic wait_ready(output int who, output int at);
    bit done;
    done = 1'b0;
    who  = -1;
    at   = cyc;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (|dif.o_req_ready) begin
        for (int j = 0; j < NR; j++) if (dif.o_req_ready[j]) who = j;
        at   = cyc;
        done = 1'b1;
      end
    end
    if (!done) chk("ready timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) chk("idle timeout", busy, 0);
  endtask

  task automatic set_req(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd);
    dif.i_req_we[k]            = we;
    dif.i_req_addr[k*AW +: AW]  = a;
    dif.i_req_wdata[k*DW +: DW] = wd;
  endtask

  task automatic do_txn(input int k, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
    int who, at;
    @(posedge clk); #1;
    set_req(k, we, a, wd);
    dif.i_req_valid[k] = 1'b1;
    wait_ready(who, at);
    chk("txn grant", who, k);
    if (who == k) push_txn(we, a, wd, at, k, exp_rd);
    @(posedge clk); #1;
    dif.i_req_valid[k] = 1'b0;
    @(negedge clk);
    chk("ready one cycle", dif.o_req_ready, 0);
    wait_idle();
  endtask

  task automatic run_rr(input logic we, input logic [31:0] base, input int n, input int gap);
    int who, at, prev;
    prev = 0;
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) set_req(k, we, base + 32'(k * 16), 32'hD0D0_0000 + 32'(k));
    dif.i_req_valid = '1;
    for (int i = 0; i < n; i++) begin
      wait_ready(who, at);
      chk("rr grant order", who, i % NR);
      if (i > 0) chk("rr grant spacing", at - prev, gap);
      prev = at;
      if (who >= 0)
        push_txn(we, base + 32'(who * 16), 32'hD0D0_0000 + 32'(who), at, who,
                 rd_model(base + 32'(who * 16)));
    end
    @(posedge clk); #1;
    dif.i_req_valid = '0;
    wait_idle();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

`ifdef DRAM_ARB_HOST_PRIORITY_EN
  task automatic prio_test();
    int who, at;
    int exp_o[5];
    exp_o = '{0, 0, 0, 1, 2};
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 32'h3000 + 32'(k * 16), 32'hE0E0_0000 + 32'(k));
    dif.i_req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      wait_ready(who, at);
      chk("host priority order", who, exp_o[i]);
      if (who >= 0)
        push_txn(1'b1, 32'h3000 + 32'(who * 16), 32'hE0E0_0000 + 32'(who), at, who, 32'h0);
      if (i == 2) begin
        @(posedge clk); #1;
        dif.i_req_valid[0] = 1'b0;
      end
    end
    @(posedge clk); #1;
    dif.i_req_valid = '0;
    wait_idle();
  endtask
`endif

  initial begin
    vec_t tbl[6];
    int   who, at, at2;
    tbl[0] = '{1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[1] = '{2, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678};
    tbl[2] = '{0, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'hC0DE_0200};
    tbl[3] = '{0, 1'b1, 32'h0000_0008, 32'h0000_00FF, 32'h0000_0000};
    tbl[4] = '{2, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h0000_0000};
    tbl[5] = '{1, 1'b0, 32'h0000_1234, 32'h0000_0055, 32'hC0DE_1234};

    dif.i_req_valid = '0;
    dif.i_req_we    = '0;
    dif.i_req_addr  = '0;
    dif.i_req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset ready", dif.o_req_ready, 0);
    chk("reset rsp_valid", dif.o_rsp_valid, 0);
    chk("reset strobes", {dif.o_dram_we, dif.o_dram_re}, 0);
    chk("reset dram addr", dif.o_dram_addr, 0);
    chk("reset dram wdata", dif.o_dram_wdata, 0);
    chk("reset rsp rdata", dif.o_rsp_rdata, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_txn(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
    chk("dram addr holds after issue", dif.o_dram_addr, tbl[5].addr);
    chk("strobes low in idle", {dif.o_dram_we, dif.o_dram_re}, 0);

    // req0 withdraws while the port is busy; only req1 is served afterwards.
    @(posedge clk); #1;
    set_req(2, 1'b0, 32'h0000_0040, 32'h0);
    dif.i_req_valid = 3'b100;
    wait_ready(who, at);
    chk("drop seq first grant", who, 2);
    if (who == 2) push_txn(1'b0, 32'h40, 32'h0, at, 2, 32'h1234_5678);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0000_0300, 32'h0);
    set_req(1, 1'b1, 32'h0000_0500, 32'h1111_2222);
    dif.i_req_valid = 3'b011;
    @(posedge clk); #1;
    dif.i_req_valid[0] = 1'b0;
    wait_ready(who, at2);
    chk("dropped req not granted", who, 1);
    chk("pending waits for idle", at2 - at, RL + 3);
    if (who == 1) push_txn(1'b1, 32'h500, 32'h1111_2222, at2, 1, 32'h0);
    @(posedge clk); #1;
    dif.i_req_valid = '0;
    wait_idle();

    // Reset during WAIT_RD kills the read with no response.
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0000_0777, 32'h0);
    dif.i_req_valid = 3'b010;
    wait_ready(who, at);
    chk("pre-reset grant", who, 1);
    if (who == 1) iss_q.push_back('{1'b0, 32'h777, 32'h0, at + 1});
    @(posedge clk); #1;
    dif.i_req_valid = '0;
    @(posedge clk); #2;
    chk("busy in wait_rd", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset strobes", {dif.o_dram_we, dif.o_dram_re}, 0);
    chk("async reset rsp_valid", dif.o_rsp_valid, 0);
    chk("async reset addr", dif.o_dram_addr, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_rr(1'b1, 32'h2000, 1, 2);

`ifdef DRAM_ARB_HOST_PRIORITY_EN
    pulse_reset();
    prio_test();
`else
    pulse_reset();
    run_rr(1'b0, 32'h1000, 6, RL + 3);
`endif

    repeat (6) @(negedge clk);
    chk("issue scoreboard drained", 64'(iss_q.size()), 0);
    chk("response scoreboard drained", 64'(rsp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single DRAM port between several requesters, e.g. the SPI host bridge, the GPU command/fetch path and the raster/writeback path.
- Accepts one transaction at a time over a valid/ready handshake.
- Issues each accepted transaction to DRAM as a single-cycle strobe.
- For reads, waits a fixed DRAM latency and returns the data to the owning requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 32, DRAM address width.
- DATA_WIDTH, 32, DRAM data width.
- READ_LATENCY, 2, cycles from the read strobe to valid i_dram_rdata (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_we  in  NUM_REQ  per-requester write enable (1 = write, 0 = read).
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same slicing rule.
- o_req_ready  out  NUM_REQ  one-hot accept strobe.
- o_rsp_valid  out  NUM_REQ  one-hot read-response strobe.
- o_rsp_rdata  out  DATA_WIDTH  read data; meaningful while any o_rsp_valid bit is high.
- o_dram_we  out  1  DRAM write strobe.
- o_dram_re  out  1  DRAM read strobe.
- o_dram_addr  out  ADDR_WIDTH  DRAM address.
- o_dram_wdata  out  DATA_WIDTH  DRAM write data.
- i_dram_rdata  in  DATA_WIDTH  DRAM read data.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, last_grant=NUM_REQ-1, all registered outputs 0, o_busy=0.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If any i_req_valid bit is set, choose the winner by round-robin, searching from last_grant+1 upward and wrapping mod NUM_REQ.
  - o_req_ready[winner]=1 combinationally in the same cycle; at most one ready bit is ever high.
  - On that clock edge: latch we/addr/wdata/owner, set last_grant=winner, go to ISSUE.
- Requester handshake rules:
  - Hold valid and request fields stable until ready is sampled high.
  - Dropping valid before ready is legal; nothing is recorded.
  - A requester may re-assert valid on the cycle after its ready.
- ISSUE (exactly 1 cycle):
  - o_dram_addr and o_dram_wdata driven from the latched registers.
  - o_dram_we=latched we; o_dram_re=~latched we.
  - Write: next state IDLE; no response is generated.
  - Read: load the latency counter with READ_LATENCY, next state WAIT_RD.
- WAIT_RD:
  - Counter decrements each cycle.
  - When the counter reaches 1, sample i_dram_rdata into o_rsp_rdata at that edge and go to RESP.
  - Total: READ_LATENCY cycles in WAIT_RD.
- RESP (exactly 1 cycle): o_rsp_valid[owner]=1, o_rsp_rdata stable; next state IDLE.
- Outside ISSUE: o_dram_we=o_dram_re=0; o_dram_addr and o_dram_wdata hold their last value.
- Occupancy per transaction:
  - Write: 2 cycles (accept in IDLE, then ISSUE).
  - Read: READ_LATENCY+3 cycles.
- No new request is accepted outside IDLE. Pending requests simply wait.
- Fairness: all NUM_REQ requesters continuously valid → grants are served cyclically, with no requester served twice before every other one has been served once.
- Reset asserted mid-transaction: immediate return to the reset values. The in-flight read returns no response, and the strobes drop asynchronously.

Optional Feature:
- DRAM_ARB_HOST_PRIORITY_EN defined:
  - Requester 0 (host bridge) has strict priority in IDLE whenever i_req_valid[0]=1.
  - last_grant is not updated on a requester-0 grant, so round-robin order among 1..NUM_REQ-1 is preserved.
- Undefined: pure round-robin over all requesters, as described above.

Test Plan:
- Reset, then req1 write addr=0x100 wdata=0xDEADBEEF → ready[1] for 1 cycle; next cycle o_dram_we=1, addr=0x100, wdata=0xDEADBEEF for 1 cycle; no rsp_valid.
- req2 read addr=0x40, DRAM model returns 0x12345678 two cycles after o_dram_re → rsp_valid[2] pulses exactly READ_LATENCY+2 cycles after ready[2], o_rsp_rdata=0x12345678.
- All 3 valid continuously with reads, starting from reset → grant order 0,1,2,0,1,2; each ready pulse is 5 cycles apart; never two ready bits high.
- req0 valid drops before it is granted while req1 is valid → only req1 is served; no DRAM strobe for req0.
- rst_n asserted during WAIT_RD → o_busy=0 and strobes=0 immediately; no rsp_valid; after release, the next grant goes to req0.
- With DRAM_ARB_HOST_PRIORITY_EN defined, req0 re-requests every cycle while req1/req2 are valid → req0 wins every arbitration; once req0 idles, req1 is served, then req2.
